// File: rtl/intr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// intr_ctrl_pkg
//   Shared constants and types for the interrupt controller:
//   register offsets within the port window, command codes accepted at
//   offset 0, FSM state encoding, reset constants and a one-hot helper.
// ---------------------------------------------------------------------------
package intr_ctrl_pkg;

  // Register offsets relative to BASE_PORT
  localparam logic [1:0] OFS_CMD = 2'd0;  // EOI / read-back select (w), IRR or ISR (r)
  localparam logic [1:0] OFS_IMR = 2'd1;  // interrupt mask register
  localparam logic [1:0] OFS_VEC = 2'd2;  // vector base register

  // Number of registers in the port window
  localparam logic [15:0] PORT_SPAN = 16'd3;

  // Commands written to offset 0
  localparam logic [7:0] CMD_EOI_NS = 8'h20;      // non-specific EOI
  localparam logic [4:0] CMD_EOI_SP = 5'b01100;   // specific EOI: 8'h60 | line
  localparam logic [7:0] CMD_RD_IRR = 8'h0A;      // read-back selects IRR
  localparam logic [7:0] CMD_RD_ISR = 8'h0B;      // read-back selects ISR

  // Reset constants
  localparam logic [7:0] IMR_RESET         = 8'hFF;
  localparam logic [7:0] VEC_RESET_DEFAULT = 8'h08;

  // Request FSM: IDLE looks for a winner, WAIT holds a toggled request
  // until the core copies intr onto intl.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // One-hot mask for a 3-bit line index
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
//   8-bit priority encoder, lowest set bit wins (bit 0 = highest priority).
// Ports:
//   i_vec    in   8  request vector
//   o_idx    out  3  index of lowest set bit (0 when none set)
//   o_valid  out  1  1 when any bit of i_vec is set
// ---------------------------------------------------------------------------
module prio_enc8 (
  input  logic [7:0] i_vec,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // Scan from the top down so the last hit, the lowest bit, is kept.
  always_comb begin
    o_idx   = 3'd0;
    o_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = 3'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//   Responder side of the core's toggle-handshake interrupt interface.
//   Rising edges on irq_in are latched into IRR, arbitrated by fixed
//   priority (line 0 highest) against the in-service register ISR
//   (fully nested), and issued by toggling intr with the vector on irq.
//   The core accepts by copying intr onto intl.
//
// Handshake: a request is outstanding exactly while intr != intl. The
//   controller toggles intr only when intr == intl, and never withdraws a
//   toggle; irq and the latched line index are stable while outstanding.
//   The acknowledge is seen in the first cycle where intl == intr again.
//
// Ports:
//   clock        in   1   system clock, all state on posedge
//   reset_n      in   1   synchronous active-low reset
//   irq_in       in   8   asynchronous request lines, rising-edge triggered
//   port         in   16  port address from core
//   port_clk     in   1   port access strobe, access on 0->1
//   port_o       in   8   write data from core
//   port_w       in   1   1 = write, 0 = read
//   port_i       out  8   read data to core (combinational)
//   irq          out  8   interrupt vector
//   intr         out  1   request toggle
//   intl         in   1   acknowledge toggle
//   o_dbg_state  out  1   current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_PORT = 16'h0020,
  parameter logic [7:0]  VEC_RESET = VEC_RESET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_in,
  input  logic [15:0] port,
  input  logic        port_clk,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [7:0]  port_i,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl,
  output logic        o_dbg_state
);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_prev;
  logic       r_pclk_q;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic [7:0] r_vbase;
  logic       r_rdsel;     // 0 = IRR, 1 = ISR on offset-0 reads
  state_t     r_state;
  logic       r_intr;
  logic [7:0] r_irq;
  logic [2:0] r_cur;       // line index of the outstanding request

  // -------------------------------------------------------------------------
  // Wires
  // -------------------------------------------------------------------------
  logic [7:0]  w_edge;
  logic        w_stb;
  logic [15:0] w_ofs;
  logic        w_hit;
  logic        w_wr;
  logic        w_wr_cmd;
  logic        w_wr_imr;
  logic        w_wr_vec;
  logic [7:0]  w_pend;
  logic [2:0]  w_best;
  logic        w_pend_v;
  logic [2:0]  w_ibest;
  logic        w_isr_v;
  logic        w_issue;
  logic        w_ack;
  logic [7:0]  w_ack_mask;
  logic [7:0]  w_eoi_clr;

  // -------------------------------------------------------------------------
  // Request edge detection: two-flop synchroniser, then a prev flop.
  // An edge is visible here two cycles after the input rises and lands in
  // IRR on the third.
  // -------------------------------------------------------------------------
  assign w_edge = r_sync2 & ~r_prev;

  // -------------------------------------------------------------------------
  // Port decode. A strobe held high produces a single access because only
  // the 0->1 transition of port_clk is accepted. r_pclk_q resets to 1 so a
  // port_clk already high out of reset is not taken as an access.
  // -------------------------------------------------------------------------
  assign w_stb    = port_clk & ~r_pclk_q;
  assign w_ofs    = port - BASE_PORT;
  assign w_hit    = (w_ofs < PORT_SPAN);
  assign w_wr     = w_stb & port_w & w_hit;
  assign w_wr_cmd = w_wr & (w_ofs[1:0] == OFS_CMD);
  assign w_wr_imr = w_wr & (w_ofs[1:0] == OFS_IMR);
  assign w_wr_vec = w_wr & (w_ofs[1:0] == OFS_VEC);

  // Reads are side-effect free and do not depend on the strobe.
  always_comb begin
    port_i = 8'h00;
    if (w_hit) begin
      case (w_ofs[1:0])
        OFS_CMD: port_i = r_rdsel ? r_isr : r_irr;
        OFS_IMR: port_i = r_imr;
        OFS_VEC: port_i = r_vbase;
        default: port_i = 8'h00;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_pend = r_irr & ~r_imr;

  prio_enc8 u_pend_enc (
    .i_vec   (w_pend),
    .o_idx   (w_best),
    .o_valid (w_pend_v)
  );

  prio_enc8 u_isr_enc (
    .i_vec   (r_isr),
    .o_idx   (w_ibest),
    .o_valid (w_isr_v)
  );

  // With nothing in service the ISR bound is effectively 8, so any pending
  // line may be issued; otherwise only strictly higher priority lines nest.
  assign w_issue = (r_state == ST_IDLE) && w_pend_v &&
                   (!w_isr_v || (w_best < w_ibest));

  assign w_ack      = (r_state == ST_WAIT) && (intl == r_intr);
  assign w_ack_mask = w_ack ? onehot8(r_cur) : 8'h00;

  // EOI target comes from ISR as registered, so an acknowledge landing in
  // the same cycle cannot be the bit a non-specific EOI removes.
  always_comb begin
    w_eoi_clr = 8'h00;
    if (w_wr_cmd) begin
      if (port_o == CMD_EOI_NS) begin
        if (w_isr_v) w_eoi_clr = onehot8(w_ibest);
      end else if (port_o[7:3] == CMD_EOI_SP) begin
        w_eoi_clr = onehot8(port_o[2:0]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file and request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1  <= 8'h00;
      r_sync2  <= 8'h00;
      r_prev   <= 8'h00;
      r_pclk_q <= 1'b1;
      r_irr    <= 8'h00;
      r_isr    <= 8'h00;
      r_imr    <= IMR_RESET;
      r_vbase  <= VEC_RESET;
      r_rdsel  <= 1'b0;
    end else begin
      r_sync1  <= irq_in;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_pclk_q <= port_clk;

      // A fresh edge on the line being acknowledged wins over the clear,
      // so that interrupt is delivered again once it leaves service.
      r_irr <= (r_irr & ~w_ack_mask) | w_edge;
      r_isr <= (r_isr & ~w_eoi_clr) | w_ack_mask;

      if (w_wr_imr) r_imr   <= port_o;
      if (w_wr_vec) r_vbase <= port_o;

      if (w_wr_cmd && (port_o == CMD_RD_IRR)) begin
        r_rdsel <= 1'b0;
      end else if (w_wr_cmd && (port_o == CMD_RD_ISR)) begin
        r_rdsel <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM. irq and r_cur are captured at issue and held through WAIT,
  // so later IMR or vbase writes cannot alter an outstanding request.
  // WAIT has no timeout: the core may leave interrupts disabled for as long
  // as it likes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_intr  <= 1'b0;
      r_irq   <= VEC_RESET;
      r_cur   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_irq   <= r_vbase + {5'd0, w_best};
            r_cur   <= w_best;
            r_intr  <= ~r_intr;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign intr        = r_intr;
  assign irq         = r_irq;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
//   Directed scenarios followed by a randomized run checked against a
//   register-level model of the controller (IRR/ISR/IMR/vbase as plain
//   variables, priority by lowest-set-bit search).
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

  localparam logic [15:0] BASE = 16'h0020;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq_in = 8'h00;
  logic [15:0] port = 16'h0000;
  logic        port_clk = 1'b0;
  logic [7:0]  port_o = 8'h00;
  logic        port_w = 1'b0;
  logic [7:0]  port_i;
  logic [7:0]  irq;
  logic        intr;
  logic        intl = 1'b0;
  logic        dbg_state;

  always #5 clock = ~clock;

  intr_ctrl #(.BASE_PORT(BASE), .VEC_RESET(8'h08)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .irq_in      (irq_in),
    .port        (port),
    .port_clk    (port_clk),
    .port_o      (port_o),
    .port_w      (port_w),
    .port_i      (port_i),
    .irq         (irq),
    .intr        (intr),
    .intl        (intl),
    .o_dbg_state (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  logic [7:0] m_irr, m_isr, m_imr, m_vbase;
  logic [7:0] exp_q[$];

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; intl = 1'b0; irq_in = 8'h00; port_clk = 1'b0; port_w = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic port_wr(input logic [1:0] ofs, input logic [7:0] data);
    @(negedge clock);
    port = BASE + {14'd0, ofs}; port_o = data; port_w = 1'b1; port_clk = 1'b1;
    @(negedge clock);
    port_clk = 1'b0; port_w = 1'b0;
  endtask

  task automatic port_rd_addr(input logic [15:0] addr, output logic [7:0] data);
    @(negedge clock);
    port = addr; port_w = 1'b0;
    #1 data = port_i;
  endtask

  task automatic read_irr(output logic [7:0] v);
    port_wr(2'd0, 8'h0A);
    port_rd_addr(BASE, v);
  endtask

  task automatic read_isr(output logic [7:0] v);
    port_wr(2'd0, 8'h0B);
    port_rd_addr(BASE, v);
  endtask

  task automatic pulse(input logic [7:0] lines);
    @(negedge clock);
    irq_in = irq_in | lines;
    tick(2);
    irq_in = irq_in & ~lines;
  endtask

  task automatic ack();
    @(negedge clock);
    intl = intr;
    tick(3);
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("FAIL reset_intr: got %b want 0", intr); end
    tests_run++;
    if (irq !== 8'h08) begin tests_failed++; $display("FAIL reset_irq: got %h want 08", irq); end
    port_rd_addr(BASE, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("FAIL reset_irr: got %h want 00", v); end
    port_rd_addr(BASE + 16'd1, v);
    tests_run++;
    if (v !== 8'hFF) begin tests_failed++; $display("FAIL reset_imr: got %h want ff", v); end
    port_rd_addr(BASE + 16'd2, v);
    tests_run++;
    if (v !== 8'h08) begin tests_failed++; $display("FAIL reset_vbase: got %h want 08", v); end
  endtask

  task automatic test_single_latency();
    logic [7:0] v;
    port_wr(2'd1, 8'hFE);
    @(negedge clock);
    irq_in[0] = 1'b1;
    tick(3);
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("FAIL latency_early: got intr=%b want 0", intr); end
    tick(1);
    irq_in[0] = 1'b0;
    tests_run++;
    if (intr !== 1'b1 || irq !== 8'h08) begin
      tests_failed++; $display("FAIL latency_issue: got intr=%b irq=%h want 1/08", intr, irq);
    end
    ack();
    read_isr(v);
    tests_run++;
    if (v !== 8'h01) begin tests_failed++; $display("FAIL single_isr: got %h want 01", v); end
    read_irr(v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("FAIL single_irr: got %h want 00", v); end
    port_wr(2'd0, 8'h20);
  endtask

  task automatic test_priority_eoi();
    logic [7:0] v;
    port_wr(2'd2, 8'h70);
    port_wr(2'd1, 8'h00);
    pulse(8'h28);
    tick(4);
    tests_run++;
    if (intr === intl || irq !== 8'h73) begin
      tests_failed++; $display("FAIL prio_first: got out=%b irq=%h want 1/73", intr !== intl, irq);
    end
    ack();
    tick(3);
    tests_run++;
    if (intr !== intl) begin tests_failed++; $display("FAIL prio_blocked: got outstanding want idle"); end
    read_isr(v);
    tests_run++;
    if (v !== 8'h08) begin tests_failed++; $display("FAIL prio_isr: got %h want 08", v); end
    port_wr(2'd0, 8'h20);
    tick(2);
    tests_run++;
    if (intr === intl || irq !== 8'h75) begin
      tests_failed++; $display("FAIL prio_second: got out=%b irq=%h want 1/75", intr !== intl, irq);
    end
    ack();
    port_wr(2'd0, 8'h20);
  endtask

  task automatic test_nested();
    logic [7:0] v;
    pulse(8'h40);
    tick(4);
    ack();
    pulse(8'h04);
    tick(4);
    tests_run++;
    if (intr === intl || irq !== 8'h72) begin
      tests_failed++; $display("FAIL nested_vec: got out=%b irq=%h want 1/72", intr !== intl, irq);
    end
    ack();
    read_isr(v);
    tests_run++;
    if (v !== 8'h44) begin tests_failed++; $display("FAIL nested_isr: got %h want 44", v); end
    port_wr(2'd0, 8'h66);
    read_isr(v);
    tests_run++;
    if (v !== 8'h04) begin tests_failed++; $display("FAIL specific_eoi: got %h want 04", v); end
    port_wr(2'd0, 8'h20);
  endtask

  task automatic test_mask_during_wait();
    logic [7:0] v;
    pulse(8'h02);
    tick(4);
    port_wr(2'd1, 8'hFF);
    port_wr(2'd2, 8'h90);
    tick(2);
    tests_run++;
    if (intr === intl || irq !== 8'h71) begin
      tests_failed++; $display("FAIL wait_hold: got out=%b irq=%h want 1/71", intr !== intl, irq);
    end
    ack();
    read_isr(v);
    tests_run++;
    if (v !== 8'h02) begin tests_failed++; $display("FAIL wait_commit: got %h want 02", v); end
    port_wr(2'd0, 8'h20);
    port_wr(2'd1, 8'h00);
    port_wr(2'd2, 8'h70);
  endtask

  task automatic test_ack_edge_collision();
    logic [7:0] v;
    pulse(8'h10);
    tick(4);
    // Re-raise line 4 so its edge reaches IRR in the acknowledge cycle.
    @(negedge clock);
    irq_in[4] = 1'b1;
    tick(2);
    intl = intr;
    tick(1);
    irq_in[4] = 1'b0;
    tick(2);
    read_irr(v);
    tests_run++;
    if (v !== 8'h10) begin tests_failed++; $display("FAIL collide_irr: got %h want 10", v); end
    read_isr(v);
    tests_run++;
    if (v !== 8'h10) begin tests_failed++; $display("FAIL collide_isr: got %h want 10", v); end
    port_wr(2'd0, 8'h20);
    tick(2);
    tests_run++;
    if (intr === intl || irq !== 8'h74) begin
      tests_failed++; $display("FAIL collide_redeliver: got out=%b irq=%h want 1/74", intr !== intl, irq);
    end
    ack();
    port_wr(2'd0, 8'h20);
  endtask

  task automatic test_readback_strobe();
    logic [7:0] v;
    pulse(8'h08); tick(4); ack();
    pulse(8'h02); tick(4); ack();
    pulse(8'h20); tick(5);
    read_isr(v);
    tests_run++;
    if (v !== 8'h0A) begin tests_failed++; $display("FAIL rd_isr: got %h want 0a", v); end
    read_irr(v);
    tests_run++;
    if (v !== 8'h20) begin tests_failed++; $display("FAIL rd_irr: got %h want 20", v); end
    port_rd_addr(BASE + 16'd3, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("FAIL rd_outside: got %h want 00", v); end
    // Hold the strobe high for several cycles with a non-specific EOI.
    @(negedge clock);
    port = BASE; port_o = 8'h20; port_w = 1'b1; port_clk = 1'b1;
    tick(5);
    port_clk = 1'b0; port_w = 1'b0;
    read_isr(v);
    tests_run++;
    if (v !== 8'h08) begin tests_failed++; $display("FAIL strobe_once: got %h want 08", v); end
    port_wr(2'd0, 8'h20);
    tick(2);
    tests_run++;
    if (intr === intl || irq !== 8'h75) begin
      tests_failed++; $display("FAIL rd_unblock: got out=%b irq=%h want 1/75", intr !== intl, irq);
    end
    ack();
    port_wr(2'd0, 8'h20);
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] v;
    pulse(8'h01);
    tick(4);
    @(negedge clock);
    reset_n = 1'b0; intl = 1'b0;
    @(negedge clock);
    tests_run++;
    if (intr !== 1'b0 || irq !== 8'h08) begin
      tests_failed++; $display("FAIL rst_wait: got intr=%b irq=%h want 0/08", intr, irq);
    end
    port_rd_addr(BASE + 16'd1, v);
    tests_run++;
    if (v !== 8'hFF) begin tests_failed++; $display("FAIL rst_wait_imr: got %h want ff", v); end
    port_rd_addr(BASE + 16'd2, v);
    tests_run++;
    if (v !== 8'h08) begin tests_failed++; $display("FAIL rst_wait_vbase: got %h want 08", v); end
    reset_n = 1'b1;
    tick(3);
    read_isr(v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("FAIL rst_wait_isr: got %h want 00", v); end
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_quiet: got intr=%b want 0", intr); end
  endtask

  // Issue and acknowledge every request the model says is eligible.
  task automatic drain(input int iter);
    for (int k = 0; k < 9; k++) begin
      int b, ib;
      logic [7:0] ev;
      b  = lowest(m_irr & ~m_imr);
      ib = lowest(m_isr);
      tests_run++;
      if (b < ib) begin
        ev = m_vbase + 8'(b);
        exp_q.push_back(ev);
        ev = exp_q.pop_front();
        if (intr === intl || irq !== ev) begin
          tests_failed++;
          $display("FAIL rand_issue[%0d]: got out=%b irq=%h want 1/%h", iter, intr !== intl, irq, ev);
        end
        ack();
        m_irr[b] = 1'b0;
        m_isr[b] = 1'b1;
      end else begin
        if (intr !== intl) begin
          tests_failed++; $display("FAIL rand_idle[%0d]: got outstanding want idle", iter);
          intl = intr;
          tick(3);
        end
        break;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v, d;
    int n;
    do_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_vbase = 8'h08;
    port_wr(2'd1, 8'h00); m_imr = 8'h00;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          d = 8'($urandom_range(1, 255));
          pulse(d);
          m_irr = m_irr | d;
        end
        2: begin
          port_wr(2'd0, 8'h20);
          n = lowest(m_isr);
          if (n < 8) m_isr[n] = 1'b0;
        end
        3: begin
          n = $urandom_range(0, 7);
          port_wr(2'd0, 8'h60 | 8'(n));
          m_isr[n] = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            d = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            port_wr(2'd1, d);
            m_imr = d;
          end else begin
            d = 8'($urandom_range(0, 255));
            port_wr(2'd2, d);
            m_vbase = d;
          end
        end
      endcase
      tick(6);
      drain(it);
      read_irr(v);
      tests_run++;
      if (v !== m_irr) begin tests_failed++; $display("FAIL rand_irr[%0d]: got %h want %h", it, v, m_irr); end
      read_isr(v);
      tests_run++;
      if (v !== m_isr) begin tests_failed++; $display("FAIL rand_isr[%0d]: got %h want %h", it, v, m_isr); end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_latency();
    test_priority_eoi();
    test_nested();
    test_mask_during_wait();
    test_ack_edge_collision();
    test_readback_strobe();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
